dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `data_memory`. It shares the memory between the CPU load/store path (port 0) and a debug/loader port (port 1). It drives the memory's write/read strobes, address and write data, and returns registered read data. It also sequences a full-memory clear. It sits between the MEM-stage logic and `data_memory`.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in `data_memory`; word index is `addr[log2(DEPTH)+1:2]`.
- `STARVE_MAX`, 4: in fixed-priority mode, the number of consecutive CPU grants after which a waiting debug request wins once.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data.
- `cpu_gnt`  out  1  one-cycle pulse; the access is being issued this cycle.
- `cpu_rvalid`  out  1  one-cycle pulse; response is valid.
- `cpu_rdata`  out  32  load data; 0 for stores and errors.
- `cpu_err`  out  1  qualifies `cpu_rvalid`; misaligned or out-of-range address.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`, `dbg_err`: same as the `cpu_*` signals, for port 1.
- `clr_req`  in  1  level request to clear the whole memory.
- `clr_done`  out  1  one-cycle pulse when the clear has completed.
- `mem_write_memory`  out  1  to `data_memory` write enable.
- `mem_read_memory`  out  1  to `data_memory` read enable.
- `mem_addr`  out  32  to `data_memory` `addr_From_Alu_Result`.
- `mem_write_data`  out  32  to `data_memory` `write_data`.
- `mem_rst`  out  1  to `data_memory` `rst` (active-high clear).
- `mem_read_data`  in  32  from `data_memory` `read_data`.

## Operation
States: IDLE, ACCESS, CLEAR.

IDLE:
- If `clr_req`=1, go to CLEAR. Clear wins over any access request.
- Otherwise, if any request is pending, arbitrate, latch the winner's port/we/addr/wdata, and go to ACCESS.
- Otherwise, stay in IDLE.

ACCESS (exactly 1 cycle):
- Assert the winner's `*_gnt`.
- If the address is legal, drive `mem_addr`/`mem_write_data` from the latch and assert `mem_write_memory`=we or `mem_read_memory`=!we.
- Legal means `addr[1:0]`==0 and `addr >> 2` < `DEPTH`.
- If the address is illegal, both memory strobes stay 0 and memory is not touched.
- At the end of the cycle, capture `mem_read_data` (load) or 0 (store/error) into the winner's rdata register, and return to IDLE.

CLEAR (exactly 1 cycle):
- Assert `mem_rst`=1, pulse `clr_done` on the following cycle, and return to IDLE.
- A `clr_req` still high in IDLE starts another clear. The requester must drop `clr_req` on `clr_done`.

Arbitration:
- Only one port is granted per ACCESS.
- The loser keeps `req` high and is reconsidered in the next IDLE.
- Fixed-priority mode: the CPU wins ties. A saturating counter counts consecutive CPU grants while `dbg_req`=1. When it reaches `STARVE_MAX`, debug wins the next tie and the counter clears. The counter also clears on any debug grant.

Requester rules:
- Request signals must stay stable while `req`=1 and `gnt`=0.
- Dropping `req` before `gnt` is legal. The request is then forgotten, unless it was already latched in ACCESS, in which case the access completes.

## Timing
- Reset (`rst`=0, asynchronous):
  - state goes to IDLE.
  - all `*_gnt`, `*_rvalid`, `*_err`, `clr_done`, `mem_write_memory`, `mem_read_memory` and `mem_rst` go to 0.
  - `mem_addr`, `mem_write_data` and both rdata registers go to 0.
  - the starvation counter goes to 0 and the round-robin pointer is set to CPU.
- Access latency: with `req` seen in IDLE at cycle N, `gnt` is high in N+1 and `rvalid`/`rdata`/`err` are high in N+2.
- Throughput: one access per 2 cycles. A second request can be accepted in the IDLE of N+2, overlapping its `rvalid`.
- Memory strobes are high only in ACCESS cycles; `mem_rst` is high only in CLEAR cycles.
- If reset asserts during ACCESS or CLEAR, the operation is aborted and no `rvalid` or `clr_done` is produced.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - true round-robin between the two ports.
  - a 1-bit pointer flips to the other port after every grant.
  - on a tie, the port the pointer names wins.
  - the starvation counter and `STARVE_MAX` are not compiled.
- Not defined: fixed CPU priority with starvation relief, as described above.

## Test plan
- Reset then CPU store 0x88 to 0x04 -> `cpu_gnt` in cycle 1, `mem_write_memory`=1 with `mem_addr`=0x04; then a load from 0x04 -> `cpu_rvalid` with `cpu_rdata`=0x00000088, `cpu_err`=0.
- CPU load from 0x01 (misaligned), and separately from 0x100 with `DEPTH`=64 -> no memory strobe; `cpu_rvalid` with `cpu_err`=1, `cpu_rdata`=0.
- CPU and debug requesting continuously, fixed priority, `STARVE_MAX`=4 -> grant order C,C,C,C,D,C,C,C,C,D. With `DMEM_ARB_RR_EN` -> C,D,C,D.
- `clr_req` raised together with `cpu_req` after storing 0xFF at 0x08 -> CLEAR first (`mem_rst` for 1 cycle, then `clr_done`), then the CPU load from 0x08 returns 0x00000000.
- Debug store of 0xCC to 0x04 with `rst` pulsed low during ACCESS -> no `dbg_rvalid`; all outputs are 0 on the next edge.
- CPU `req` dropped before its grant while debug is granted -> no `cpu_gnt` and no `cpu_rvalid` follow.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if;
  // port 0: CPU load/store path
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  // port 1: debug/loader path
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_err;
  // full-memory clear handshake
  logic        clr_req;
  logic        clr_done;
  // data_memory side
  logic        mem_write_memory;
  logic        mem_read_memory;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_rst;
  logic [31:0] mem_read_data;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  clr_req,
    output clr_done,
    output mem_write_memory, mem_read_memory, mem_addr, mem_write_data, mem_rst,
    input  mem_read_data
  );

  // requester and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output clr_req,
    input  clr_done,
    input  mem_write_memory, mem_read_memory, mem_addr, mem_write_data, mem_rst,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for data_memory; DMEM_ARB_RR_EN selects round-robin
module dmem_arbiter #(
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CLEAR} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_q, state_d;
  logic        port_q, port_d;    // 0 = CPU, 1 = debug
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        cpu_rvalid_q, cpu_err_q;
  logic        dbg_rvalid_q, dbg_err_q;
  logic [31:0] cpu_rdata_q, dbg_rdata_q;
  logic        clr_done_q;

  logic        win_dbg;
  logic        accept;
  logic        in_access;
  logic        legal;

`ifdef DMEM_ARB_RR_EN
  logic        rr_q, rr_d;        // port favoured on the next tie
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  logic [CW-1:0] starve_q, starve_d;
`endif

  assign accept    = (state_q == S_IDLE) && !bus.clr_req && (bus.cpu_req || bus.dbg_req);
  assign in_access = (state_q == S_ACCESS);
  assign legal     = (addr_q[1:0] == 2'b00) && ((addr_q >> 2) < DEPTH_W);

  // Pick the winning port for the current IDLE cycle.
  always_comb begin
    win_dbg = 1'b0;
    if (bus.cpu_req && bus.dbg_req) begin
`ifdef DMEM_ARB_RR_EN
      win_dbg = rr_q;
`else
      win_dbg = (starve_q == STARVE_LIM);
`endif
    end else begin
      win_dbg = bus.dbg_req;
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; clear beats any access, ACCESS and CLEAR each last one cycle.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
        end else if (bus.cpu_req || bus.dbg_req) begin
          state_d = S_ACCESS;
          port_d  = win_dbg;
          we_d    = win_dbg ? bus.dbg_we    : bus.cpu_we;
          addr_d  = win_dbg ? bus.dbg_addr  : bus.cpu_addr;
          wdata_d = win_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      S_CLEAR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Grants and memory strobes, decoded from the registered state only.
  always_comb begin
    bus.cpu_gnt          = in_access && !port_q;
    bus.dbg_gnt          = in_access && port_q;
    bus.mem_write_memory = in_access && legal && we_q;
    bus.mem_read_memory  = in_access && legal && !we_q;
    bus.mem_addr         = (in_access && legal) ? addr_q  : '0;
    bus.mem_write_data   = (in_access && legal) ? wdata_q : '0;
    bus.mem_rst          = (state_q == S_CLEAR);
    bus.cpu_rvalid       = cpu_rvalid_q;
    bus.cpu_err          = cpu_err_q;
    bus.cpu_rdata        = cpu_rdata_q;
    bus.dbg_rvalid       = dbg_rvalid_q;
    bus.dbg_err          = dbg_err_q;
    bus.dbg_rdata        = dbg_rdata_q;
    bus.clr_done         = clr_done_q;
  end

  // Response registers: rvalid/err/clr_done pulse the cycle after ACCESS/CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      clr_done_q   <= 1'b0;
    end else begin
      cpu_rvalid_q <= in_access && !port_q;
      cpu_err_q    <= in_access && !port_q && !legal;
      dbg_rvalid_q <= in_access && port_q;
      dbg_err_q    <= in_access && port_q && !legal;
      clr_done_q   <= (state_q == S_CLEAR);
      if (in_access && !port_q) begin
        cpu_rdata_q <= (legal && !we_q) ? bus.mem_read_data : '0;
      end
      if (in_access && port_q) begin
        dbg_rdata_q <= (legal && !we_q) ? bus.mem_read_data : '0;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Pointer names the port that lost the latest grant.
  always_comb begin
    rr_d = accept ? ~win_dbg : rr_q;
  end

  // Round-robin pointer register, starts on the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`else
  // Count consecutive CPU wins over a waiting debug request; any debug win clears it.
  always_comb begin
    starve_d = starve_q;
    if (accept) begin
      if (win_dbg) begin
        starve_d = '0;
      end else if (bus.dbg_req) begin
        if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`endif

endmodule
